// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and hazard helper for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned CTRL_BUS     = 5;
    localparam int unsigned STALL_PC     = 0;
    localparam int unsigned STALL_IF_ID  = 1;
    localparam int unsigned STALL_ID_EX  = 2;
    localparam int unsigned STALL_EX_MEM = 3;
    localparam int unsigned STALL_MEM_WB = 4;

    localparam logic [31:0] ZERO_WORD     = '0;
    localparam logic [4:0]  ZERO_REG_ADDR = '0;

    typedef enum logic [1:0] {
        PCTRL_RUN = 2'd0,
        PCTRL_LD  = 2'd1,
        PCTRL_MC  = 2'd2
    } pctrl_state_e;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard
    function automatic logic load_use_haz(
        input logic       is_load,
        input logic       regs_wen,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       rs1_ren,
        input logic [4:0] rs2,
        input logic       rs2_ren
    );
        return is_load && regs_wen && (rd != ZERO_REG_ADDR) &&
               ((rs1_ren && (rs1 == rd)) || (rs2_ren && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use bubbles, multi-cycle EX sequencing with
// timeout watchdog, and fetch redirect on EX jumps.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [4:0]          id_rs1_addr_i,
    input  logic [4:0]          id_rs2_addr_i,
    input  logic                id_rs1_ren_i,
    input  logic                id_rs2_ren_i,
    input  logic [4:0]          ex_rd_addr_i,
    input  logic                ex_regs_wen_i,
    input  logic                ex_is_load_i,
    input  logic                ex_mc_start_i,
    input  logic                ex_mc_done_i,
    input  logic                ex_jump_i,
    input  logic [31:0]         ex_jump_addr_i,
    output logic [CTRL_BUS-1:0] stall_o,
    output logic [CTRL_BUS-1:0] flush_o,
    output logic                jump_o,
    output logic [31:0]         jump_addr_o,
    output logic                mc_err_o,
    output logic [1:0]          state_o
);

    localparam logic [7:0] LD_INIT = (LOAD_LAT > 1) ? 8'(LOAD_LAT - 2) : 8'd0;
    localparam logic [7:0] MC_LAST = 8'(MC_TIMEOUT - 1);

    pctrl_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         haz;

    assign haz = load_use_haz(ex_is_load_i, ex_regs_wen_i, ex_rd_addr_i,
                              id_rs1_addr_i, id_rs1_ren_i,
                              id_rs2_addr_i, id_rs2_ren_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= PCTRL_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        stall_o     = '0;
        flush_o     = '0;
        jump_o      = 1'b0;
        jump_addr_o = ZERO_WORD;

        unique case (state_q)
            PCTRL_RUN: begin
                if (ex_jump_i) begin
                    jump_o               = 1'b1;
                    jump_addr_o          = ex_jump_addr_i;
                    flush_o[STALL_IF_ID] = 1'b1;
                    flush_o[STALL_ID_EX] = 1'b1;
                end else if (ex_mc_start_i) begin
                    // a result ready in the start cycle needs no wait at all
                    if (!ex_mc_done_i) begin
                        stall_o[STALL_PC]     = 1'b1;
                        stall_o[STALL_IF_ID]  = 1'b1;
                        stall_o[STALL_ID_EX]  = 1'b1;
                        flush_o[STALL_EX_MEM] = 1'b1;
                        state_d               = PCTRL_MC;
                        cnt_d                 = '0;
                    end
                end else if (haz) begin
                    stall_o[STALL_PC]    = 1'b1;
                    stall_o[STALL_IF_ID] = 1'b1;
                    flush_o[STALL_ID_EX] = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = PCTRL_LD;
                        cnt_d   = LD_INIT;
                    end
                end
            end

            PCTRL_LD: begin
                stall_o[STALL_PC]    = 1'b1;
                stall_o[STALL_IF_ID] = 1'b1;
                flush_o[STALL_ID_EX] = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = PCTRL_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            PCTRL_MC: begin
                if (ex_mc_done_i) begin
                    state_d = PCTRL_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == MC_LAST) begin
                    err_d   = 1'b1;
                    state_d = PCTRL_RUN;
                    cnt_d   = '0;
                end else begin
                    stall_o[STALL_PC]     = 1'b1;
                    stall_o[STALL_IF_ID]  = 1'b1;
                    stall_o[STALL_ID_EX]  = 1'b1;
                    flush_o[STALL_EX_MEM] = 1'b1;
                    cnt_d                 = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = PCTRL_RUN;
                cnt_d   = '0;
            end
        endcase

        // outputs are held at zero for as long as reset is asserted
        if (!rstn) begin
            stall_o     = '0;
            flush_o     = '0;
            jump_o      = 1'b0;
            jump_addr_o = ZERO_WORD;
        end
    end

    assign mc_err_o = err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: two instances (LOAD_LAT=1/MC_TIMEOUT=64
// and LOAD_LAT=3/MC_TIMEOUT=8) share one stimulus bus.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_ren, id_rs2_ren, ex_regs_wen, ex_is_load;
    logic        ex_mc_start, ex_mc_done, ex_jump;
    logic [31:0] ex_jump_addr;

    logic [4:0]  a_stall, a_flush, b_stall, b_flush;
    logic        a_jump, b_jump, a_err, b_err;
    logic [31:0] a_jaddr, b_jaddr;
    logic [1:0]  a_state, b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.LOAD_LAT(1), .MC_TIMEOUT(64)) dut_a (
        .clk(clk), .rstn(rstn),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_ren_i(id_rs1_ren), .id_rs2_ren_i(id_rs2_ren),
        .ex_rd_addr_i(ex_rd_addr), .ex_regs_wen_i(ex_regs_wen),
        .ex_is_load_i(ex_is_load), .ex_mc_start_i(ex_mc_start),
        .ex_mc_done_i(ex_mc_done), .ex_jump_i(ex_jump),
        .ex_jump_addr_i(ex_jump_addr),
        .stall_o(a_stall), .flush_o(a_flush), .jump_o(a_jump),
        .jump_addr_o(a_jaddr), .mc_err_o(a_err), .state_o(a_state)
    );

    pipe_ctrl #(.LOAD_LAT(3), .MC_TIMEOUT(8)) dut_b (
        .clk(clk), .rstn(rstn),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_ren_i(id_rs1_ren), .id_rs2_ren_i(id_rs2_ren),
        .ex_rd_addr_i(ex_rd_addr), .ex_regs_wen_i(ex_regs_wen),
        .ex_is_load_i(ex_is_load), .ex_mc_start_i(ex_mc_start),
        .ex_mc_done_i(ex_mc_done), .ex_jump_i(ex_jump),
        .ex_jump_addr_i(ex_jump_addr),
        .stall_o(b_stall), .flush_o(b_flush), .jump_o(b_jump),
        .jump_addr_o(b_jaddr), .mc_err_o(b_err), .state_o(b_state)
    );

    task automatic idle_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_ren = 0; id_rs2_ren = 0;
        ex_rd_addr = '0; ex_regs_wen = 0; ex_is_load = 0;
        ex_mc_start = 0; ex_mc_done = 0; ex_jump = 0; ex_jump_addr = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [4:0] rs1, input logic r1en,
                              input logic [4:0] rs2, input logic r2en);
        ex_is_load = 1; ex_regs_wen = 1; ex_rd_addr = rd;
        id_rs1_addr = rs1; id_rs1_ren = r1en; id_rs2_addr = rs2; id_rs2_ren = r2en;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({a_stall, a_flush, a_jump, a_jaddr, a_err, a_state} !== 45'd0) begin
            errors++;
            $display("FAIL reset_a: got %h want 0", {a_stall, a_flush, a_jump, a_jaddr, a_err, a_state});
        end
        checks++;
        if ({b_stall, b_flush, b_jump, b_jaddr, b_err, b_state} !== 45'd0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0", {b_stall, b_flush, b_jump, b_jaddr, b_err, b_state});
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (a_stall !== 5'b00011) begin errors++; $display("FAIL lu_stall: got %b want 00011", a_stall); end
        checks++;
        if (a_flush !== 5'b00100) begin errors++; $display("FAIL lu_flush: got %b want 00100", a_flush); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({a_stall, a_flush, a_state} !== 12'd0) begin
            errors++; $display("FAIL lu_release: got %h want 0", {a_stall, a_flush, a_state});
        end
        next_cycle();
        drive_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({a_stall, a_flush} !== 10'd0) begin
            errors++; $display("FAIL lu_rd0: got %h want 0", {a_stall, a_flush});
        end
        next_cycle();
        drive_load(5'd5, 5'd5, 1'b0, 5'd9, 1'b1);
        @(negedge clk);
        checks++;
        if ({a_stall, a_flush} !== 10'd0) begin
            errors++; $display("FAIL lu_noren: got %h want 0", {a_stall, a_flush});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_load_lat3();
        logic [4:0] exp_stall [4];
        logic [1:0] exp_state [4];
        exp_stall = '{5'b00011, 5'b00011, 5'b00011, 5'b00000};
        exp_state = '{2'd0, 2'd1, 2'd1, 2'd0};
        apply_reset();
        drive_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (b_stall !== exp_stall[i] || b_state !== exp_state[i]) begin
                errors++;
                $display("FAIL ld3_cycle%0d: got stall=%b state=%0d want stall=%b state=%0d",
                         i, b_stall, b_state, exp_stall[i], exp_state[i]);
            end
            next_cycle();
            if (i == 0) idle_inputs();
        end
    endtask

    task automatic test_jump();
        apply_reset();
        drive_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        ex_jump = 1; ex_jump_addr = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (a_jump !== 1'b1 || a_jaddr !== 32'h100 || a_flush !== 5'b00110 || a_stall !== 5'b00000) begin
            errors++;
            $display("FAIL jump_a: got j=%b addr=%h flush=%b stall=%b want 1 100 00110 00000",
                     a_jump, a_jaddr, a_flush, a_stall);
        end
        checks++;
        if (b_jump !== 1'b1 || b_jaddr !== 32'h100 || b_flush !== 5'b00110 || b_stall !== 5'b00000) begin
            errors++;
            $display("FAIL jump_b: got j=%b addr=%h flush=%b stall=%b want 1 100 00110 00000",
                     b_jump, b_jaddr, b_flush, b_stall);
        end
        next_cycle();
        idle_inputs();
        ex_jump_addr = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (b_jump !== 1'b0 || b_jaddr !== 32'h0 || b_state !== 2'd0) begin
            errors++;
            $display("FAIL jump_after: got j=%b addr=%h state=%0d want 0 0 0", b_jump, b_jaddr, b_state);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_mc_done();
        apply_reset();
        ex_mc_start = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (i < 9) begin
                if (a_stall !== 5'b00111 || a_flush !== 5'b01000 || a_jump !== 1'b0) begin
                    errors++;
                    $display("FAIL mc_wait%0d: got stall=%b flush=%b j=%b want 00111 01000 0",
                             i, a_stall, a_flush, a_jump);
                end
            end else begin
                if ({a_stall, a_flush, a_jump} !== 11'd0 || a_state !== 2'd2) begin
                    errors++;
                    $display("FAIL mc_done: got stall=%b flush=%b state=%0d want 0 0 2",
                             a_stall, a_flush, a_state);
                end
            end
            next_cycle();
            ex_mc_start = 0;
            if (i == 4) begin ex_jump = 1; ex_jump_addr = 32'h0000_0200; end
            if (i == 5) begin ex_jump = 0; ex_jump_addr = '0; end
            if (i == 8) ex_mc_done = 1;
        end
        ex_mc_done = 0;
        @(negedge clk);
        checks++;
        if (a_state !== 2'd0 || a_stall !== 5'd0) begin
            errors++; $display("FAIL mc_exit: got state=%0d stall=%b want 0 0", a_state, a_stall);
        end
        apply_reset();
        ex_mc_start = 1; ex_mc_done = 1;
        @(negedge clk);
        checks++;
        if (a_stall !== 5'd0 || a_flush !== 5'd0) begin
            errors++; $display("FAIL mc_same_cycle: got stall=%b flush=%b want 0 0", a_stall, a_flush);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (a_state !== 2'd0) begin
            errors++; $display("FAIL mc_same_state: got %0d want 0", a_state);
        end
    endtask

    task automatic test_mc_timeout();
        apply_reset();
        ex_mc_start = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (i < 8) begin
                if (b_stall !== 5'b00111 || b_err !== 1'b0) begin
                    errors++;
                    $display("FAIL to_wait%0d: got stall=%b err=%b want 00111 0", i, b_stall, b_err);
                end
            end else begin
                if (b_stall !== 5'd0 || b_state !== 2'd2 || b_err !== 1'b0) begin
                    errors++;
                    $display("FAIL to_release: got stall=%b state=%0d err=%b want 0 2 0",
                             b_stall, b_state, b_err);
                end
            end
            next_cycle();
            ex_mc_start = 0;
        end
        @(negedge clk);
        checks++;
        if (b_err !== 1'b1 || b_state !== 2'd0) begin
            errors++; $display("FAIL to_err: got err=%b state=%0d want 1 0", b_err, b_state);
        end
        repeat (5) next_cycle();
        checks++;
        if (b_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky: got %b want 1", b_err);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (b_err !== 1'b0) begin
            errors++; $display("FAIL to_clear: got %b want 0", b_err);
        end
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset_mid_mc();
        apply_reset();
        ex_mc_start = 1;
        next_cycle();
        ex_mc_start = 0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (a_stall !== 5'b00111 || a_state !== 2'd2) begin
            errors++; $display("FAIL rst_mid_pre: got stall=%b state=%0d want 00111 2", a_stall, a_state);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({a_stall, a_flush, a_jump, a_jaddr, a_err, a_state} !== 45'd0 ||
            {b_stall, b_flush, b_jump, b_jaddr, b_err, b_state} !== 45'd0) begin
            errors++;
            $display("FAIL rst_mid: got a=%h b=%h want 0",
                     {a_stall, a_flush, a_jump, a_jaddr, a_err, a_state},
                     {b_stall, b_flush, b_jump, b_jaddr, b_err, b_state});
        end
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        drive_load(5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (a_stall !== 5'b00011 || a_flush !== 5'b00100) begin
            errors++; $display("FAIL rst_mid_haz: got stall=%b flush=%b want 00011 00100", a_stall, a_flush);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        test_reset();
        test_load_use();
        test_load_lat3();
        test_jump();
        test_mc_done();
        test_mc_timeout();
        test_reset_mid_mc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
